// File: rtl/signed_seq_alu.sv
// ---------------------------------------------------------------------------
// signed_seq_alu
//   Multi-cycle signed arithmetic unit. ADD and SUB finish in one cycle.
//   MUL uses shift-add on operand magnitudes and produces the full 2*WIDTH
//   product. DIV uses restoring division on magnitudes and produces a
//   truncating quotient and a remainder. Both take WIDTH cycles in CALC and
//   then one FIX cycle that applies the sign correction.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        operation request, accepted only while busy=0
//   OpCode       00 ADD, 01 SUB, 10 MUL, 11 DIV (sampled with start)
//   A, B         signed operands (dividend / divisor for DIV)
//   busy         operation in progress (CALC or FIX)
//   done         one-cycle pulse when the results are valid
//   result_lo    sum/difference, low product half, or quotient
//   result_hi    sign extension, high product half, or remainder
//   overflow     signed overflow flag
//   div_by_zero  DIV issued with B == 0
// ---------------------------------------------------------------------------
module signed_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       OpCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    count;
  logic             op_div;
  logic             neg_res;
  logic             neg_rem;
  logic             b_zero;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;

  logic             accept;
  logic [WIDTH:0]   as_sum;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign accept = start && !busy;

  // ADD/SUB is evaluated on WIDTH+1 bits so the exact result is available;
  // its top bit gives the sign extension and overflow is top bit != bit W-1.
  assign as_sum = OpCode[0] ? ({A[WIDTH-1], A} - {B[WIDTH-1], B})
                            : ({A[WIDTH-1], A} + {B[WIDTH-1], B});

  // Magnitudes: the most negative value negates to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
  assign a_abs = A[WIDTH-1] ? -A : A;
  assign b_abs = B[WIDTH-1] ? -B : B;

  // One shift-add step: {acc, mq} holds the partial product with the
  // remaining multiplier bits in the low part of mq.
  assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});

  // One restoring-division step: the partial remainder is always below
  // |B| <= 2^(WIDTH-1), so the shifted value fits in WIDTH+1 bits.
  assign div_shift = {acc, mq[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_mag});
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, b_mag}) : div_shift[WIDTH-1:0];

  // Sign correction. Negating a zero magnitude yields zero, so a zero
  // product or quotient never turns into a spurious negative value.
  assign prod_fix = neg_res ? -{acc, mq} : {acc, mq};
  assign quo_fix  = neg_res ? -mq : mq;
  assign rem_fix  = neg_rem ? -acc : acc;

  // Next-state logic: ADD/SUB jump straight to DONE, MUL/DIV spend WIDTH
  // cycles in CALC and one in FIX. DONE accepts a new request directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = OpCode[1] ? CALC : DONE;
      end
      CALC: begin
        if (count == CW'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        if (start) state_d = OpCode[1] ? CALC : DONE;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and datapath. Results and flags only change when an
  // ADD/SUB is accepted or when a MUL/DIV passes through FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count       <= '0;
      op_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
      a_orig      <= '0;
      b_mag       <= '0;
      acc         <= '0;
      mq          <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (!OpCode[1]) begin
              result_lo   <= as_sum[WIDTH-1:0];
              result_hi   <= {WIDTH{as_sum[WIDTH]}};
              overflow    <= as_sum[WIDTH] ^ as_sum[WIDTH-1];
              div_by_zero <= 1'b0;
            end else begin
              op_div  <= OpCode[0];
              neg_res <= A[WIDTH-1] ^ B[WIDTH-1];
              neg_rem <= A[WIDTH-1];
              b_zero  <= (B == '0);
              a_orig  <= A;
              b_mag   <= b_abs;
              acc     <= '0;
              mq      <= a_abs;
              count   <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          count <= count - CW'(1);
          if (op_div) begin
            acc <= div_rem;
            mq  <= {mq[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (op_div) begin
            if (b_zero) begin
              result_lo   <= '1;
              result_hi   <= a_orig;
              overflow    <= 1'b0;
              div_by_zero <= 1'b1;
            end else begin
              result_lo   <= quo_fix;
              result_hi   <= rem_fix;
              // A positive quotient magnitude of 2^(WIDTH-1) only arises
              // from MIN / -1 and cannot be represented.
              overflow    <= !neg_res && mq[WIDTH-1];
              div_by_zero <= 1'b0;
            end
          end else begin
            result_lo   <= prod_fix[WIDTH-1:0];
            result_hi   <= prod_fix[2*WIDTH-1:WIDTH];
            overflow    <= (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_signed_seq_alu
//   Bench for signed_seq_alu. A WIDTH=32 instance is compared every cycle
//   against an arithmetic model of the expected done/busy/result/flag values;
//   directed cases also carry hand-computed results and latencies. A WIDTH=8
//   instance covers the narrow-width latency and a few boundary values.
// ---------------------------------------------------------------------------
module tb_signed_seq_alu;

  localparam int W = 32;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        ovf;
    logic        dz;
  } res_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result_lo;
  logic [W-1:0]  result_hi;
  logic          overflow;
  logic          div_by_zero;

  logic          start8;
  logic [1:0]    op8;
  logic [7:0]    a8;
  logic [7:0]    b8;
  logic          busy8;
  logic          done8;
  logic [7:0]    lo8;
  logic [7:0]    hi8;
  logic          ovf8;
  logic          dz8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rst_cyc = -1;
  bit   check_en = 0;
  res_t held = '0;
  res_t pend = '0;
  bit   pend_valid = 0;
  int   pend_due = -1;
  int   bfrom = 1;
  int   bto = 0;
  bit   exp_done;
  bit   exp_busy;

  signed_seq_alu #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .OpCode(op), .A(a), .B(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  signed_seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .OpCode(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
    .overflow(ovf8), .div_by_zero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; sampled at the falling edge where it is stable.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sext(logic [63:0] v, int w);
    longint t;
    t = $signed(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Expected results straight from signed arithmetic on wide integers.
  function automatic res_t model(int w, logic [1:0] opc, logic [63:0] av, logic [63:0] bv);
    res_t r;
    longint x, y, v, mn, mx;
    logic [63:0] mask, bits;
    r = '0;
    x = sext(av, w);
    y = sext(bv, w);
    mask = (64'd1 << w) - 64'd1;
    mn = -(longint'(1) <<< (w - 1));
    mx = -mn - 1;
    case (opc)
      2'd0, 2'd1: begin
        v = opc[0] ? x - y : x + y;
        bits = v;
        r.lo = bits & mask;
        r.hi = (v < 0) ? mask : 64'd0;
        r.ovf = (v > mx) || (v < mn);
      end
      2'd2: begin
        v = x * y;
        bits = v;
        r.lo = bits & mask;
        bits = v >>> w;
        r.hi = bits & mask;
        r.ovf = (v > mx) || (v < mn);
      end
      default: begin
        if (y == 0) begin
          r.lo = mask;
          r.hi = av & mask;
          r.dz = 1'b1;
        end else if (x == mn && y == -1) begin
          bits = mn;
          r.lo = bits & mask;
          r.hi = 64'd0;
          r.ovf = 1'b1;
        end else begin
          bits = x / y;
          r.lo = bits & mask;
          bits = x % y;
          r.hi = bits & mask;
        end
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of the 32-bit instance against the model state.
  always @(negedge clk) begin
    if (check_en) begin
      if (cyc == rst_cyc) begin
        held = '0;
        pend_valid = 0;
        bfrom = 1;
        bto = 0;
      end
      exp_done = pend_valid && (cyc == pend_due);
      if (exp_done) begin
        held = pend;
        pend_valid = 0;
      end
      exp_busy = (cyc >= bfrom) && (cyc <= bto);
      checkOutput("cyc done", 64'(done), 64'(exp_done));
      checkOutput("cyc busy", 64'(busy), 64'(exp_busy));
      checkOutput("cyc result_lo", 64'(result_lo), held.lo);
      checkOutput("cyc result_hi", 64'(result_hi), held.hi);
      checkOutput("cyc overflow", 64'(overflow), 64'(held.ovf));
      checkOutput("cyc div_by_zero", 64'(div_by_zero), 64'(held.dz));
    end
  end

  // Drive one request; the model records it only if the unit should be idle.
  task automatic applyStimulus(input logic [1:0] opc, input logic [W-1:0] av,
                               input logic [W-1:0] bv, output bit accepted, output int n0);
    @(negedge clk);
    #1;
    n0 = cyc + 1;
    accepted = !((cyc >= bfrom) && (cyc <= bto));
    if (accepted) begin
      pend = model(W, opc, 64'(av), 64'(bv));
      pend_valid = 1;
      if (opc[1]) begin
        pend_due = n0 + W + 1;
        bfrom = n0;
        bto = n0 + W;
      end else begin
        pend_due = n0;
        bfrom = 1;
        bto = 0;
      end
    end
    op = opc;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int n0, output int lat);
    bit seen;
    seen = 0;
    lat = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (seen) lat = cyc - n0 + 1;
    else begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no done expected done within 200 cycles", name);
    end
  endtask

  task automatic runCase(string name, logic [1:0] opc, logic [W-1:0] av, logic [W-1:0] bv,
                         logic [W-1:0] elo, logic [W-1:0] ehi, logic eovf, logic edz, int elat);
    bit acc;
    int n0, lat;
    applyStimulus(opc, av, bv, acc, n0);
    waitDone(name, n0, lat);
    checkOutput({name, " latency"}, 64'(lat), 64'(elat));
    checkOutput({name, " lo"}, 64'(result_lo), 64'(elo));
    checkOutput({name, " hi"}, 64'(result_hi), 64'(ehi));
    checkOutput({name, " ovf"}, 64'(overflow), 64'(eovf));
    checkOutput({name, " dz"}, 64'(div_by_zero), 64'(edz));
  endtask

  task automatic run8(string name, logic [1:0] opc, logic [7:0] av, logic [7:0] bv,
                      logic [7:0] elo, logic [7:0] ehi, logic eovf, int elat);
    int n0;
    bit seen;
    res_t m;
    m = model(8, opc, 64'(av), 64'(bv));
    @(negedge clk);
    #1;
    n0 = cyc + 1;
    op8 = opc;
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    checkOutput({name, " done seen"}, 64'(seen), 64'(1));
    checkOutput({name, " latency"}, 64'(cyc - n0 + 1), 64'(elat));
    checkOutput({name, " lo"}, 64'(lo8), 64'(elo));
    checkOutput({name, " hi"}, 64'(hi8), 64'(ehi));
    checkOutput({name, " ovf"}, 64'(ovf8), 64'(eovf));
    checkOutput({name, " model lo"}, 64'(lo8), m.lo);
    checkOutput({name, " model hi"}, 64'(hi8), m.hi);
    checkOutput({name, " model ovf"}, 64'(ovf8), 64'(m.ovf));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    rst_cyc = cyc + 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit acc;
    int n0, lat;
    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    a = '0;
    b = '0;
    start8 = 1'b0;
    op8 = 2'd0;
    a8 = '0;
    b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1;

    @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset lo", 64'(result_lo), 64'(0));

    runCase("add ovf", 2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1);
    runCase("mul -3*7", 2'd2, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
    runCase("mul min*min", 2'd2, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1, 1'b0, 34);
    runCase("div -7/2", 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
    runCase("div 5/0", 2'd3, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b1, 34);
    runCase("sub ovf", 2'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
    runCase("div min/-1", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 34);
    runCase("add -5+3", 2'd0, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
    runCase("div 7/-2", 2'd3, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 34);
    runCase("mul 0*-5", 2'd2, 32'd0, 32'hFFFFFFFB, 32'd0, 32'd0, 1'b0, 1'b0, 34);

    // Back-to-back issue, including a request made in the DONE cycle.
    applyStimulus(2'd0, 32'd1, 32'd2, acc, n0);
    applyStimulus(2'd1, 32'd10, 32'd3, acc, n0);
    applyStimulus(2'd2, 32'd100, 32'hFFFFFF9C, acc, n0);
    repeat (W + 1) @(negedge clk);
    applyStimulus(2'd3, 32'd100, 32'd7, acc, n0);
    waitDone("b2b div", n0, lat);
    checkOutput("b2b div latency", 64'(lat), 64'(34));
    checkOutput("b2b div lo", 64'(result_lo), 64'(14));
    checkOutput("b2b div hi", 64'(result_hi), 64'(2));

    // A request while busy is dropped; the original multiply completes.
    applyStimulus(2'd2, 32'd6, 32'd7, acc, n0);
    lat = n0;
    repeat (2) @(negedge clk);
    applyStimulus(2'd2, 32'd9, 32'd9, acc, n0);
    waitDone("ignored start", lat, n0);
    checkOutput("ignored start latency", 64'(n0), 64'(34));
    checkOutput("ignored start lo", 64'(result_lo), 64'(42));
    checkOutput("ignored start hi", 64'(result_hi), 64'(0));

    // Reset in the middle of a multiply: no done, outputs cleared.
    applyStimulus(2'd2, 32'd123, 32'd456, acc, n0);
    repeat (9) @(negedge clk);
    pulseReset();
    @(negedge clk);
    checkOutput("mid reset busy", 64'(busy), 64'(0));
    checkOutput("mid reset lo", 64'(result_lo), 64'(0));
    checkOutput("mid reset hi", 64'(result_hi), 64'(0));
    repeat (W + 4) @(negedge clk);

    runCase("add after reset", 2'd0, 32'd20, 32'd22, 32'd42, 32'd0, 1'b0, 1'b0, 1);

    run8("w8 mul -3*7", 2'd2, 8'hFD, 8'h07, 8'hEB, 8'hFF, 1'b0, 10);
    run8("w8 div min/-1", 2'd3, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 10);
    run8("w8 mul min*min", 2'd2, 8'h80, 8'h80, 8'h00, 8'h40, 1'b1, 10);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
